// File: rtl/data_consumer.sv
// Counter-stream integrity checker: hunts for sequence lock, then
// counts received samples and sequence errors until lock is lost.
module data_consumer #(
  parameter int DATA_WIDTH    = 8,
  parameter int LOCK_COUNT    = 4,
  parameter int LOSS_COUNT    = 3,
  parameter int ERR_CNT_WIDTH = 16,
  parameter int RX_CNT_WIDTH  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    i_Input_Data,
  input  logic                     i_Data_Valid,
  input  logic                     i_Clear_Counters,
  output logic                     o_Locked,
  output logic                     o_Error,
  output logic [ERR_CNT_WIDTH-1:0] o_Error_Count,
  output logic [RX_CNT_WIDTH-1:0]  o_Rx_Count,
  output logic [DATA_WIDTH-1:0]    o_Last_Data
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(LOSS_COUNT + 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                state;
  logic                  have_ref;
  logic [DATA_WIDTH-1:0] expected;
  logic [GW-1:0]         good_run;
  logic [BW-1:0]         bad_run;

  logic                  match;
  logic [GW-1:0]         good_next;
  logic [BW-1:0]         bad_next;
  logic                  ecnt_full;
  logic                  rx_full;

  assign match     = (i_Input_Data == expected);
  assign good_next = good_run + GW'(1);
  assign bad_next  = bad_run + BW'(1);
  assign ecnt_full = &o_Error_Count;
  assign rx_full   = &o_Rx_Count;
  assign o_Locked  = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= HUNT;
      have_ref      <= 1'b0;
      expected      <= '0;
      good_run      <= '0;
      bad_run       <= '0;
      o_Error       <= 1'b0;
      o_Error_Count <= '0;
      o_Rx_Count    <= '0;
      o_Last_Data   <= '0;
    end else begin
      o_Error <= 1'b0;
      if (i_Data_Valid) begin
        o_Last_Data <= i_Input_Data;
        expected    <= i_Input_Data + DATA_WIDTH'(1);
        unique case (state)
          HUNT: begin
            if (!have_ref) begin
              have_ref <= 1'b1;
              good_run <= '0;
            end else if (match) begin
              if (good_next == GW'(LOCK_COUNT)) begin
                state    <= LOCKED;
                good_run <= '0;
                bad_run  <= '0;
              end else begin
                good_run <= good_next;
              end
            end else begin
              good_run <= '0;
            end
          end
          LOCKED: begin
            if (!rx_full)
              o_Rx_Count <= o_Rx_Count + RX_CNT_WIDTH'(1);
            if (match) begin
              bad_run <= '0;
            end else begin
              o_Error <= 1'b1;
              if (!ecnt_full)
                o_Error_Count <= o_Error_Count + ERR_CNT_WIDTH'(1);
              // this sample becomes the reference for relocking
              if (bad_next == BW'(LOSS_COUNT)) begin
                state    <= HUNT;
                good_run <= '0;
                bad_run  <= '0;
              end else begin
                bad_run <= bad_next;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
      if (i_Clear_Counters) begin
        o_Error_Count <= '0;
        o_Rx_Count    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_data_consumer.sv
// Bench for data_consumer: vector table, directed corner sequences,
// and randomized traffic against a sequence-rule model.
module tb_data_consumer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  din;
  logic        valid;
  logic        clr;

  logic        locked, error;
  logic [15:0] ecnt;
  logic [31:0] rx;
  logic [7:0]  last;

  logic        locked2, error2;
  logic [3:0]  ecnt2;
  logic [3:0]  rx2;
  logic [7:0]  last2;

  int n_vec = 0;
  int n_bad = 0;

  data_consumer dut (
    .clk(clk), .reset(reset), .i_Input_Data(din),
    .i_Data_Valid(valid), .i_Clear_Counters(clr),
    .o_Locked(locked), .o_Error(error), .o_Error_Count(ecnt),
    .o_Rx_Count(rx), .o_Last_Data(last)
  );

  data_consumer #(.ERR_CNT_WIDTH(4), .RX_CNT_WIDTH(4)) dut2 (
    .clk(clk), .reset(reset), .i_Input_Data(din),
    .i_Data_Valid(valid), .i_Clear_Counters(clr),
    .o_Locked(locked2), .o_Error(error2), .o_Error_Count(ecnt2),
    .o_Rx_Count(rx2), .o_Last_Data(last2)
  );

  always #5 clk = ~clk;

  // behavioural model, unbounded counts; saturation applied at compare
  bit     m_lock, m_ref, m_err;
  int     m_exp, m_good, m_bad, m_last;
  longint m_ecnt, m_rx;

  function automatic longint sat(longint v, longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit v, input int d, input bit c);
    bit hit;
    if (r) begin
      m_lock = 0; m_ref = 0; m_err = 0; m_exp = 0;
      m_good = 0; m_bad = 0; m_last = 0; m_ecnt = 0; m_rx = 0;
      return;
    end
    m_err = 0;
    if (v) begin
      hit = (d == m_exp);
      m_last = d;
      m_exp = (d + 1) % 256;
      if (!m_lock) begin
        if (!m_ref) begin
          m_ref = 1; m_good = 0;
        end else if (hit) begin
          m_good++;
          if (m_good == 4) begin m_lock = 1; m_good = 0; m_bad = 0; end
        end else m_good = 0;
      end else begin
        m_rx++;
        if (hit) m_bad = 0;
        else begin
          m_err = 1; m_ecnt++; m_bad++;
          if (m_bad == 3) begin m_lock = 0; m_good = 0; m_bad = 0; end
        end
      end
    end
    if (c) begin m_ecnt = 0; m_rx = 0; end
  endtask

  task automatic step(input bit r, input bit v, input int d, input bit c);
    reset = r; valid = v; din = 8'(d); clr = c;
    @(posedge clk);
    model(r, v, d & 255, c);
    #1;
    chk("locked", locked, m_lock);
    chk("error", error, m_err);
    chk("err_count", ecnt, sat(m_ecnt, 65535));
    chk("rx_count", rx, sat(m_rx, 64'hFFFF_FFFF));
    chk("last_data", last, m_last);
    chk("err_count4", ecnt2, sat(m_ecnt, 15));
    chk("rx_count4", rx2, sat(m_rx, 15));
    chk("locked4", locked2, m_lock);
  endtask

  typedef struct {
    bit r, v; int d; bit c;
    bit e_lock, e_err; int e_ecnt, e_rx, e_last;
  } vec_t;

  vec_t tbl[$];

  initial begin
    reset = 1'b1; valid = 1'b0; din = '0; clr = 1'b0;
    model(1, 0, 0, 0);

    // reset then lock on 0..4, first count on 5
    tbl.push_back('{1,0,0,0, 0,0,0,0,0});
    tbl.push_back('{0,1,0,0, 0,0,0,0,0});
    tbl.push_back('{0,1,1,0, 0,0,0,0,1});
    tbl.push_back('{0,1,2,0, 0,0,0,0,2});
    tbl.push_back('{0,1,3,0, 0,0,0,0,3});
    tbl.push_back('{0,1,4,0, 1,0,0,0,4});
    tbl.push_back('{0,1,5,0, 1,0,0,1,5});
    // relock near the top, then wrap through 0xFF -> 0x00
    tbl.push_back('{1,0,0,0, 0,0,0,0,0});
    tbl.push_back('{0,1,248,0, 0,0,0,0,248});
    tbl.push_back('{0,1,249,0, 0,0,0,0,249});
    tbl.push_back('{0,1,250,0, 0,0,0,0,250});
    tbl.push_back('{0,1,251,0, 0,0,0,0,251});
    tbl.push_back('{0,1,252,0, 1,0,0,0,252});
    tbl.push_back('{0,1,253,0, 1,0,0,1,253});
    tbl.push_back('{0,1,254,0, 1,0,0,2,254});
    tbl.push_back('{0,1,255,0, 1,0,0,3,255});
    tbl.push_back('{0,1,0,0,   1,0,0,4,0});
    tbl.push_back('{0,1,1,0,   1,0,0,5,1});

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].c);
      chk($sformatf("tbl%0d_locked", i), locked, tbl[i].e_lock);
      chk($sformatf("tbl%0d_error", i), error, tbl[i].e_err);
      chk($sformatf("tbl%0d_ecnt", i), ecnt, tbl[i].e_ecnt);
      chk($sformatf("tbl%0d_rx", i), rx, tbl[i].e_rx);
      chk($sformatf("tbl%0d_last", i), last, tbl[i].e_last);
    end

    // single mismatch while locked
    for (int d = 2; d <= 11; d++) step(0, 1, d, 0);
    step(0, 1, 99, 0);
    chk("t3_err_pulse", error, 1);
    chk("t3_ecnt", ecnt, 1);
    chk("t3_locked", locked, 1);
    step(0, 1, 100, 0);
    chk("t3_no_err", error, 0);
    step(0, 1, 101, 0);
    chk("t3_ecnt_hold", ecnt, 1);
    chk("t3_locked2", locked, 1);

    // three mismatches drop lock, then relock from the resync value
    step(0, 0, 0, 1);
    chk("t4_clr", ecnt, 0);
    for (int d = 102; d <= 120; d++) step(0, 1, d & 255, 0);
    step(0, 1, 50, 0);
    step(0, 1, 70, 0);
    chk("t4_still_locked", locked, 1);
    step(0, 1, 90, 0);
    chk("t4_unlocked", locked, 0);
    chk("t4_ecnt", ecnt, 3);
    for (int d = 91; d <= 93; d++) begin
      step(0, 1, d, 0);
      chk("t4_hunting", locked, 0);
      chk("t4_hunt_noerr", error, 0);
    end
    step(0, 1, 94, 0);
    chk("t4_relocked", locked, 1);
    chk("t4_ecnt_hold", ecnt, 3);

    // idle gap with junk data between 5 and 6
    while (m_exp != 5) step(0, 1, m_exp, 0);
    step(0, 1, 5, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, $urandom_range(0, 255), 0);
      chk("t5_gap_last", last, 5);
      chk("t5_gap_noerr", error, 0);
    end
    step(0, 1, 6, 0);
    chk("t5_match6", error, 0);
    chk("t5_last6", last, 6);

    // narrow error counter saturates and holds
    for (int i = 0; i < 14; i++) begin
      step(0, 1, (m_exp + 10) & 255, 0);
      step(0, 1, m_exp, 0);
    end
    chk("t5_sat4", ecnt2, 15);
    step(0, 1, (m_exp + 10) & 255, 0);
    chk("t5_sat4_hold", ecnt2, 15);
    chk("t5_sat4_pulse", error2, 1);
    step(0, 1, m_exp, 0);

    // clear coincident with a mismatch, then mid-run reset
    step(0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, (m_exp + 7) & 255, 0);
      step(0, 1, m_exp, 0);
    end
    chk("t6_ecnt2", ecnt, 2);
    step(0, 1, (m_exp + 7) & 255, 1);
    chk("t6_clr_ecnt", ecnt, 0);
    chk("t6_clr_rx", rx, 0);
    chk("t6_clr_pulse", error, 1);
    chk("t6_clr_locked", locked, 1);
    step(1, 1, 33, 0);
    chk("t6_rst_locked", locked, 0);
    chk("t6_rst_ecnt", ecnt, 0);
    chk("t6_rst_rx", rx, 0);
    chk("t6_rst_last", last, 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit r, v, c;
      int d;
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 99) == 0);
      d = ($urandom_range(0, 9) < 8) ? m_exp : $urandom_range(0, 255);
      step(r, v, d, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_consumer.md
Name: data_consumer

Overview:
Receive-side endpoint for the counter-stream data producer interface: samples the 8-bit data/valid stream and checks that every valid sample is the previous valid sample plus one, modulo 2^DATA_WIDTH. A hunt/lock state machine establishes sequence lock. Once locked, the block counts received samples and sequence errors and reports loss of lock. It sits downstream of the clock-domain-crossing path as the integrity checker for the multi-clock synchronization datapath.

Parameters:
DATA_WIDTH, 8, width of data bus and sequence arithmetic
LOCK_COUNT, 4, consecutive matching samples required in HUNT to enter LOCKED (>=1)
LOSS_COUNT, 3, consecutive mismatching samples in LOCKED that force return to HUNT (>=1)
ERR_CNT_WIDTH, 16, width of saturating error counter
RX_CNT_WIDTH, 32, width of saturating receive counter

Ports:
clk  input  1  single clock
reset  input  1  synchronous, active-high reset
i_Input_Data  input  DATA_WIDTH  sample from producer
i_Data_Valid  input  1  sample qualifier
i_Clear_Counters  input  1  synchronous clear of o_Error_Count and o_Rx_Count
o_Locked  output  1  high while in LOCKED
o_Error  output  1  one-cycle pulse per mismatch counted in LOCKED
o_Error_Count  output  ERR_CNT_WIDTH  saturating mismatch count
o_Rx_Count  output  RX_CNT_WIDTH  saturating count of valid samples accepted in LOCKED
o_Last_Data  output  DATA_WIDTH  last valid sample received

Behaviour:
- Reset (sampled on a clk edge with reset=1): state=HUNT; have_ref=0, expected=0, good_run=0, bad_run=0. All outputs 0. Reset overrides every other input.
- Cycles with i_Data_Valid=0: data is ignored; state, expected, runs and outputs hold, except that o_Error drops to 0.
- Every valid sample: o_Last_Data<=data; expected<=data+1, truncated to DATA_WIDTH. 0xFF->0x00 is a match.
- HUNT, have_ref=0: first valid sample sets have_ref=1 and good_run=0. No compare.
- HUNT, have_ref=1, match: good_run+1. When this reaches LOCK_COUNT: state<=LOCKED, good_run<=0, bad_run<=0.
- HUNT, mismatch: good_run<=0.
- HUNT never asserts o_Error and never changes either counter.
- LOCKED, any valid sample: o_Rx_Count+1, saturating at all-ones.
- LOCKED, match: bad_run<=0.
- LOCKED, mismatch: o_Error=1 for exactly the next cycle; o_Error_Count+1, saturating at all-ones; bad_run+1.
- LOCKED, when bad_run+1 reaches LOSS_COUNT: state<=HUNT, good_run<=0, have_ref stays 1. The resync value from that sample seeds the relock.
- Latency: all outputs are registered. Effects of a sample at edge N are visible after edge N, i.e. o_Locked rises the cycle after the qualifying sample.
- i_Clear_Counters=1 zeroes both counters and wins over a simultaneous increment. It does not affect state, o_Error or o_Last_Data.
- Mid-operation reset: the next cycle shows the full reset state, and lock must be reacquired from scratch.
- Back-to-back valid every cycle is supported at full rate; there is no backpressure.

Test Plan:
1. Reset, then valid every cycle with data 0,1,2,3,4,5 -> o_Locked=0 through the sample of 3, =1 the cycle after sample 4 is taken; o_Error_Count=0; o_Rx_Count=0 after 4, =1 after 5.
2. Locked, stream 0xFD,0xFE,0xFF,0x00,0x01 -> no o_Error; o_Rx_Count +5; o_Last_Data=0x01.
3. Locked, stream 10,11,99,100,101 -> one o_Error pulse in the cycle after 99; o_Error_Count=1; o_Locked stays 1; 100 and 101 are matches.
4. Locked, stream 20,50,70,90 -> o_Error_Count=3; o_Locked falls the cycle after 90. Then 91,92,93,94 -> o_Locked rises the cycle after 94, with no error increments during HUNT.
5. Locked, valid=0 for 10 cycles with random data between 5 and 6 -> no o_Error; o_Last_Data=5 during the gap; 6 is accepted as a match. Also cover o_Error_Count=0xFFFF plus one mismatch -> stays 0xFFFF.
6. Locked with o_Error_Count=2: i_Clear_Counters coincident with a mismatch -> counter=0 next cycle and o_Error still pulses. Then assert reset for one cycle while locked -> the next cycle shows o_Locked=0, both counters=0 and o_Last_Data=0.
